ascon_ps_inv: RTL and testbench

Iterative inverse of the ASCON substitution layer: accepts a 320-bit state, applies the inverse 5-bit S-box to all 64 contiguous 5-bit groups over several cycles, and returns the result through a valid/ready handshake. It sits beside the forward substitution layer. It serves the permutation self-test path and state-recovery debug, where area matters more than latency. Group packing is identical to the forward layer: group i is bits [5*i+4 : 5*i].

---
 rtl/ascon_ps_inv.sv | 109 ++++++++++
 tb/tb_ascon_ps_inv.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ps_inv.sv
// Iterative inverse ASCON substitution layer: LANES inverse S-boxes walk the
// 64 five-bit groups of a 320-bit state, one slice per cycle, behind valid/ready.
module ascon_ps_inv #(
    parameter int LANES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] S_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] S_o,
    output logic         busy
);

    localparam int N  = 64 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = 5 * LANES;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
              LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
            $error("ascon_ps_inv: LANES must be a power of two from 1 to 64");
        end
    endgenerate

    localparam logic [4:0] INV_TBL [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [319:0]    r_work;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   w_slice_in;
    logic [SW-1:0]   w_slice_out;
    logic            w_last;
    int              w_base;

    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_base     = int'(r_cnt) * SW;
    assign w_slice_in = r_work[w_base +: SW];

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_slice_out = '0;
        for (int l = 0; l < LANES; l++) begin
            w_slice_out[5*l +: 5] = INV_TBL[w_slice_in[5*l +: 5]];
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the 320-bit work register is reset explicitly because S_o must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= S_i;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_work[w_base +: SW] <= w_slice_out;
                    // Counter parks on N-1; the DONE transition replaces the wrap.
                    if (!w_last) r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign S_o       = r_work;

endmodule

// File: tb/tb_ascon_ps_inv.sv
// Bench for ascon_ps_inv: four instances (LANES 8, 1, 64, 16) checked against a
// table model built by inverting the standard forward ASCON S-box.
module tb_ascon_ps_inv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         iv  [4];
    logic         ir  [4];
    logic [319:0] si  [4];
    logic         ov  [4];
    logic         orr [4];
    logic [319:0] so  [4];
    logic         bz  [4];

    localparam int LN [4] = '{8, 1, 64, 16};

    ascon_ps_inv #(.LANES(8)) u_l8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .S_i(si[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .S_o(so[0]), .busy(bz[0]));
    ascon_ps_inv #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .S_i(si[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .S_o(so[1]), .busy(bz[1]));
    ascon_ps_inv #(.LANES(64)) u_l64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .S_i(si[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .S_o(so[2]), .busy(bz[2]));
    ascon_ps_inv #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .S_i(si[3]),
        .out_valid(ov[3]), .out_ready(orr[3]), .S_o(so[3]), .busy(bz[3]));

    // Standard forward ASCON S-box; the inverse used for expectations is derived from it.
    localparam logic [4:0] FWD [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    logic [4:0] inv_tbl [32];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [319:0] fwd_layer(input logic [319:0] x);
        logic [319:0] r;
        for (int i = 0; i < 64; i++) r[5*i +: 5] = FWD[x[5*i +: 5]];
        return r;
    endfunction

    function automatic logic [319:0] inv_layer(input logic [319:0] x);
        logic [319:0] r;
        for (int i = 0; i < 64; i++) r[5*i +: 5] = inv_tbl[x[5*i +: 5]];
        return r;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int j = 0; j < 10; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    // Present x to instance k from IDLE, wait for the result, then release it.
    task automatic transact(input int k, input logic [319:0] x,
                            output logic [319:0] y, output int lat);
        si[k] = x;
        iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        lat = 0;
        while (!ov[k] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        y = so[k];
        orr[k] = 1'b1;
        @(posedge clk); #1;
        orr[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (so[k] !== 320'd0) begin n_err++; $display("FAIL reset_S_o[%0d]: got %h want 0", k, so[k]); end
            n_cmp++; if (ov[k] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov[k]); end
            n_cmp++; if (bz[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", k, bz[k]); end
            n_cmp++; if (ir[k] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, ir[k]); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive();
        logic [319:0] x, y, exp;
        int lat;
        for (int v = 0; v < 32; v++) begin
            for (int i = 0; i < 64; i++) begin
                x[5*i +: 5]   = 5'(v);
                exp[5*i +: 5] = inv_tbl[v];
            end
            transact(0, x, y, lat);
            n_cmp++; if (y !== exp) begin n_err++; $display("FAIL exhaustive_y%02h: got %h want %h", v, y, exp); end
            n_cmp++; if (lat != 8) begin n_err++; $display("FAIL exhaustive_lat_y%02h: got %0d want 8", v, lat); end
        end
    endtask

    task automatic rt_loop(input int k);
        logic [319:0] x, y;
        int lat;
        for (int t = 0; t < 1000; t++) begin
            x = rand_state();
            transact(k, fwd_layer(x), y, lat);
            n_cmp++; if (y !== x) begin n_err++; $display("FAIL round_trip_L%0d: got %h want %h", LN[k], y, x); end
            n_cmp++; if (lat != 64 / LN[k]) begin n_err++; $display("FAIL round_trip_lat_L%0d: got %0d want %0d", LN[k], lat, 64 / LN[k]); end
        end
    endtask

    task automatic test_round_trip();
        fork
            rt_loop(0);
            rt_loop(1);
            rt_loop(2);
        join
    endtask

    task automatic test_backpressure();
        logic [319:0] x1, x2, held, y;
        int lat;
        bit stable_ok, ready_ok;
        x1 = rand_state();
        x2 = rand_state();
        if (x2 == x1) x2[0] = ~x2[0];
        si[0] = x1;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        si[0] = x2;
        lat = 0;
        while (!ov[0] && lat < 200) begin @(posedge clk); #1; lat++; end
        held = so[0];
        n_cmp++; if (held !== inv_layer(x1)) begin n_err++; $display("FAIL bp_first_result: got %h want %h", held, inv_layer(x1)); end
        stable_ok = 1'b1;
        ready_ok  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (so[0] !== held || ov[0] !== 1'b1) stable_ok = 1'b0;
            if (ir[0] !== 1'b0) ready_ok = 1'b0;
        end
        n_cmp++; if (!stable_ok) begin n_err++; $display("FAIL bp_hold: got S_o %h out_valid %b want %h and 1", so[0], ov[0], held); end
        n_cmp++; if (!ready_ok) begin n_err++; $display("FAIL bp_in_ready: got %b want 0 throughout", ir[0]); end
        orr[0] = 1'b1;
        @(posedge clk); #1;
        orr[0] = 1'b0;
        n_cmp++; if (ir[0] !== 1'b1 || bz[0] !== 1'b0) begin n_err++; $display("FAIL bp_release: got in_ready %b busy %b want 1 0", ir[0], bz[0]); end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        n_cmp++; if (bz[0] !== 1'b1) begin n_err++; $display("FAIL bp_second_accept: got busy %b want 1", bz[0]); end
        lat = 0;
        while (!ov[0] && lat < 200) begin @(posedge clk); #1; lat++; end
        y = so[0];
        n_cmp++; if (y !== inv_layer(x2)) begin n_err++; $display("FAIL bp_second_result: got %h want %h", y, inv_layer(x2)); end
        n_cmp++; if (lat != 8) begin n_err++; $display("FAIL bp_second_lat: got %0d want 8", lat); end
        orr[0] = 1'b1;
        @(posedge clk); #1;
        orr[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [319:0] x, y;
        int lat;
        bit spurious;
        si[0] = rand_state();
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int h = 0; h < 2; h++) begin
            #1;
            n_cmp++; if (so[0] !== 320'd0) begin n_err++; $display("FAIL mid_reset_S_o: got %h want 0", so[0]); end
            n_cmp++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b1) begin
                n_err++; $display("FAIL mid_reset_flags: got out_valid %b busy %b in_ready %b want 0 0 1", ov[0], bz[0], ir[0]);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ov[0] !== 1'b0) spurious = 1'b1;
        end
        n_cmp++; if (spurious) begin n_err++; $display("FAIL mid_reset_spurious: got out_valid 1 want 0"); end
        x = rand_state();
        transact(0, x, y, lat);
        n_cmp++; if (y !== inv_layer(x)) begin n_err++; $display("FAIL mid_reset_fresh: got %h want %h", y, inv_layer(x)); end
        n_cmp++; if (lat != 8) begin n_err++; $display("FAIL mid_reset_fresh_lat: got %0d want 8", lat); end
    endtask

    task automatic test_throughput();
        logic [319:0] q [$];
        logic [319:0] exp;
        int cyc, last_acc, n_acc, b;
        cyc = 0;
        last_acc = -1;
        n_acc = 0;
        orr[0] = 1'b1;
        iv[0]  = 1'b1;
        si[0]  = rand_state();
        while (n_acc < 6 && cyc < 200) begin
            if (ir[0]) begin
                if (last_acc >= 0) begin
                    n_cmp++; if (cyc - last_acc != 10) begin n_err++; $display("FAIL tput_interval: got %0d want 10", cyc - last_acc); end
                end
                last_acc = cyc;
                n_acc++;
                q.push_back(si[0]);
            end
            @(posedge clk); #1;
            cyc++;
            si[0] = rand_state();
            if (ov[0]) begin
                exp = (q.size() > 0) ? inv_layer(q.pop_front()) : '0;
                n_cmp++; if (so[0] !== exp) begin n_err++; $display("FAIL tput_result: got %h want %h", so[0], exp); end
            end
        end
        iv[0] = 1'b0;
        n_cmp++; if (n_acc != 6) begin n_err++; $display("FAIL tput_accepts: got %0d want 6", n_acc); end
        b = 0;
        while (!ov[0] && b < 50) begin @(posedge clk); #1; b++; end
        exp = (q.size() > 0) ? inv_layer(q.pop_front()) : '0;
        n_cmp++; if (ov[0] !== 1'b1 || so[0] !== exp) begin n_err++; $display("FAIL tput_last: got %h valid %b want %h", so[0], ov[0], exp); end
        @(posedge clk); #1;
        orr[0] = 1'b0;
    endtask

    task automatic test_partial();
        logic [319:0] x, exp;
        int lat;
        x = rand_state();
        exp = inv_layer(x);
        si[3] = x;
        iv[3] = 1'b1;
        @(posedge clk); #1;
        iv[3] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (so[3][79:0] !== exp[79:0]) begin n_err++; $display("FAIL partial_low: got %h want %h", so[3][79:0], exp[79:0]); end
        n_cmp++; if (so[3][319:80] !== x[319:80]) begin n_err++; $display("FAIL partial_high: got %h want %h", so[3][319:80], x[319:80]); end
        lat = 1;
        while (!ov[3] && lat < 200) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL partial_lat: got %0d want 4", lat); end
        n_cmp++; if (so[3] !== exp) begin n_err++; $display("FAIL partial_final: got %h want %h", so[3], exp); end
        orr[3] = 1'b1;
        @(posedge clk); #1;
        orr[3] = 1'b0;
    endtask

    initial begin
        for (int y = 0; y < 32; y++) inv_tbl[FWD[y]] = 5'(y);
        for (int k = 0; k < 4; k++) begin
            iv[k]  = 1'b0;
            orr[k] = 1'b0;
            si[k]  = '0;
        end
        test_reset();
        test_exhaustive();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_throughput();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
